uart_led_ctrl: RTL and testbench

- Parametrised LED/timebase controller fed by the UART RX/TX byte interfaces (i_RX_DV/i_RX_Byte in, i_TX_DV/i_TX_Byte out).
- Decodes two-byte commands that set each of N_CH LED channels to OFF, ON, PWM or BLINK, and acknowledges each command over TX.
- Holds the phase-accumulator PPS generator and the seconds counter that drive the blink and minute-mark outputs.
- Sits between the UART_RX/UART_TX instances and the board RGB pins in top.

---
 rtl/uart_led_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_uart_led_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_led_ctrl.sv
// LED/timebase controller driven by UART byte streams: decodes two-byte channel
// commands and legacy single-byte commands, acknowledges over TX, and runs the PPS/seconds timebase.
module uart_led_ctrl #(
   parameter int          N_CH         = 3,
   parameter int          PWM_BITS     = 8,
   parameter int          ACC_BITS     = 32,
   parameter int unsigned PPS_INC      = 172,
   parameter int          SECS_MOD     = 60,
   parameter int          TIMEOUT_CLKS = 250000,
   parameter int          LEGACY_CH    = 1
) (
   input  logic                        i_Clock,
   input  logic                        i_Reset,
   input  logic                        i_RX_DV,
   input  logic [7:0]                  i_RX_Byte,
   input  logic                        i_TX_Active,
   output logic                        o_TX_DV,
   output logic [7:0]                  o_TX_Byte,
   output logic [N_CH-1:0]             o_LED,
   output logic                        o_PPS,
   output logic [$clog2(SECS_MOD)-1:0] o_Secs,
   output logic                        o_Minute
);

   localparam int SECS_W = $clog2(SECS_MOD);
   localparam int TMO_W  = $clog2(TIMEOUT_CLKS);

   localparam logic [ACC_BITS:0] INC_EXT   = (ACC_BITS+1)'(PPS_INC);
   localparam logic [SECS_W-1:0] SECS_LAST = SECS_W'(SECS_MOD - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]        RSP_ACK   = 8'h06;
   localparam logic [7:0]        RSP_NAK   = 8'h15;
   localparam logic [7:0]        LEGACY_ON = 8'h31;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_PWM   = 2'b10,
      MODE_BLINK = 2'b11
   } mode_t;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_WAIT_DATA = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ACC_BITS-1:0] r_acc;
   logic                r_pps;
   logic [ACC_BITS:0]   w_acc_sum;
   logic [SECS_W-1:0]   r_secs;
   logic [3:0]          r_hdr_ch;
   mode_t               r_hdr_mode;
   logic [TMO_W-1:0]    r_tmo;
   mode_t               r_mode [N_CH];
   logic [7:0]          r_val  [N_CH];
   logic [PWM_BITS-1:0] r_pwm;
   logic [N_CH-1:0]     r_led;
   logic                r_pend;
   logic [7:0]          r_pend_byte;
   logic                r_tx_dv;
   logic [7:0]          r_tx_byte;

   logic                w_hdr_load;
   logic                w_legacy;
   logic                w_wr;
   logic                w_rsp_valid;
   logic [7:0]          w_rsp_byte;
   logic                w_ch_ok;
   logic                w_tx_fire;

   // Timebase: the carry out of the accumulator is the one-cycle PPS tick.
   assign w_acc_sum = {1'b0, r_acc} + INC_EXT;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_acc  <= '0;
         r_pps  <= 1'b0;
         r_secs <= '0;
         r_pwm  <= '0;
      end else begin
         r_acc <= w_acc_sum[ACC_BITS-1:0];
         r_pps <= w_acc_sum[ACC_BITS];
         r_pwm <= r_pwm + PWM_BITS'(1);
         if (int'(r_secs) >= SECS_MOD) begin
            r_secs <= '0;
         end else if (r_pps) begin
            r_secs <= (r_secs == SECS_LAST) ? '0 : r_secs + SECS_W'(1);
         end
      end
   end

   assign w_ch_ok = ({28'd0, r_hdr_ch} < N_CH);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A byte arriving on the timeout cycle still counts as the data byte.
   always_comb begin
      w_state_next = r_state;
      w_hdr_load   = 1'b0;
      w_legacy     = 1'b0;
      w_wr         = 1'b0;
      w_rsp_valid  = 1'b0;
      w_rsp_byte   = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (i_RX_DV) begin
               if (i_RX_Byte[7]) begin
                  w_hdr_load   = 1'b1;
                  w_state_next = S_WAIT_DATA;
               end else begin
                  w_legacy = 1'b1;
               end
            end
         end
         S_WAIT_DATA: begin
            if (i_RX_DV) begin
               w_state_next = S_IDLE;
               w_rsp_valid  = 1'b1;
               w_wr         = w_ch_ok;
               w_rsp_byte   = w_ch_ok ? RSP_ACK : RSP_NAK;
            end else if (r_tmo == TMO_LAST) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_hdr_ch   <= '0;
         r_hdr_mode <= MODE_OFF;
         r_tmo      <= '0;
      end else begin
         if (w_hdr_load) begin
            r_hdr_ch   <= i_RX_Byte[3:0];
            r_hdr_mode <= mode_t'(i_RX_Byte[6:5]);
            r_tmo      <= '0;
         end else if (r_state == S_WAIT_DATA && !i_RX_DV && r_tmo != TMO_LAST) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         for (int i = 0; i < N_CH; i++) begin
            r_mode[i] <= MODE_OFF;
            r_val[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_wr && r_hdr_ch == 4'(i)) begin
               r_mode[i] <= r_hdr_mode;
               r_val[i]  <= i_RX_Byte;
            end else if (w_legacy && i == LEGACY_CH) begin
               r_mode[i] <= (i_RX_Byte == LEGACY_ON) ? MODE_ON : MODE_OFF;
            end
         end
      end
   end

   // One-deep response slot; a newer response replaces an unsent one.
   assign w_tx_fire = r_pend && !i_TX_Active;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_pend      <= 1'b0;
         r_pend_byte <= '0;
         r_tx_dv     <= 1'b0;
         r_tx_byte   <= '0;
      end else begin
         r_tx_dv <= w_tx_fire;
         if (w_tx_fire) begin
            r_tx_byte <= r_pend_byte;
         end
         if (w_rsp_valid) begin
            r_pend      <= 1'b1;
            r_pend_byte <= w_rsp_byte;
         end else if (w_tx_fire) begin
            r_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_led <= '1;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            case (r_mode[i])
               MODE_OFF:   r_led[i] <= 1'b1;
               MODE_ON:    r_led[i] <= 1'b0;
               MODE_PWM:   r_led[i] <= !(r_pwm < PWM_BITS'(r_val[i]));
               MODE_BLINK: r_led[i] <= r_acc[ACC_BITS-1];
               default:    r_led[i] <= 1'b1;
            endcase
         end
      end
   end

   assign o_TX_DV   = r_tx_dv;
   assign o_TX_Byte = r_tx_byte;
   assign o_LED     = r_led;
   assign o_PPS     = r_pps;
   assign o_Secs    = r_secs;
   assign o_Minute  = (r_secs != '0);

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Directed and randomized bench for uart_led_ctrl with a fast timebase and short
// header-to-data timeout; expectations come from a command-level model.
module tb_uart_led_ctrl;

  localparam int          N_CH = 3;
  localparam int          TMO  = 40;
  localparam int          SMOD = 4;
  localparam int unsigned INC  = 32'h0800_0000;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_TX_Active;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic [N_CH-1:0] o_LED;
  logic       o_PPS;
  logic [1:0] o_Secs;
  logic       o_Minute;

  int vectors = 0;
  int miscompares = 0;
  int n_cyc;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int m_mode[N_CH];
  int m_val[N_CH];

  uart_led_ctrl #(
    .N_CH(N_CH), .PWM_BITS(8), .ACC_BITS(32), .PPS_INC(INC),
    .SECS_MOD(SMOD), .TIMEOUT_CLKS(TMO), .LEGACY_CH(1)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .i_TX_Active(i_TX_Active), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_LED(o_LED),
    .o_PPS(o_PPS), .o_Secs(o_Secs), .o_Minute(o_Minute)
  );

  // clock / reset-relative cycle count
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) n_cyc <= 0;
    else n_cyc <= n_cyc + 1;
  end

  always @(negedge i_Clock) begin
    if (o_TX_DV === 1'b1) obs_q.push_back(o_TX_Byte);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1);
  end

  // reference model, expressed in whole seconds / cycle counts
  function automatic longint unsigned pps_count(input int n);
    return (longint'(n) * longint'(INC)) >> 32;
  endfunction

  function automatic logic exp_pps(input int n);
    return (pps_count(n) != pps_count(n - 1));
  endfunction

  function automatic int exp_secs(input int n);
    if (n == 0) return 0;
    return int'(pps_count(n - 1) % SMOD);
  endfunction

  function automatic logic exp_blink_led(input int n);
    longint unsigned phase;
    phase = (longint'(n - 1) * longint'(INC)) % 64'h1_0000_0000;
    return (phase < 64'h8000_0000) ? 1'b0 : 1'b1;
  endfunction

  function automatic int exp_window(input int ch);
    case (m_mode[ch])
      0: return 0;
      1: return 256;
      2: return m_val[ch];
      default: return 128;
    endcase
  endfunction

  function automatic logic [7:0] model_cmd(input logic [7:0] hdr, input logic [7:0] data);
    int ch;
    ch = int'(hdr & 8'h0F);
    if (ch < N_CH) begin
      m_mode[ch] = int'((hdr >> 5) & 8'h03);
      m_val[ch]  = int'(data);
      return 8'h06;
    end
    return 8'h15;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0;
      m_val[i]  = 0;
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clock);
    i_RX_DV   = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge i_Clock);
  endtask

  task automatic send_cmd(input logic [7:0] hdr, input logic [7:0] data);
    exp_q.push_back(model_cmd(hdr, data));
    send_byte(hdr);
    send_byte(data);
  endtask

  task automatic expect_tx(input string tag);
    logic [31:0] got;
    logic [31:0] want;
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) @(negedge i_Clock);
    got  = (obs_q.size() != 0) ? {24'd0, obs_q.pop_front()} : 32'hFFFF_FFFF;
    want = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hEEEE_EEEE;
    chk(tag, got, want);
  endtask

  task automatic expect_quiet(input string tag, input int k);
    idle(k);
    chk(tag, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic led_window(input string tag);
    int cnt[N_CH];
    for (int i = 0; i < N_CH; i++) cnt[i] = 0;
    repeat (256) begin
      @(negedge i_Clock);
      for (int i = 0; i < N_CH; i++) if (o_LED[i] === 1'b0) cnt[i]++;
    end
    for (int i = 0; i < N_CH; i++) chk($sformatf("%s_ch%0d", tag, i), cnt[i], exp_window(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_led"}, o_LED, {N_CH{1'b1}});
    chk({tag, "_txdv"}, o_TX_DV, 0);
    chk({tag, "_txbyte"}, o_TX_Byte, 0);
    chk({tag, "_pps"}, o_PPS, 0);
    chk({tag, "_secs"}, o_Secs, 0);
    chk({tag, "_minute"}, o_Minute, 0);
  endtask

  initial begin
    logic [7:0] hdr;
    logic [7:0] dat;
    logic [7:0] rsp;
    i_Reset = 1'b1;
    i_RX_DV = 1'b0;
    i_RX_Byte = 8'h00;
    i_TX_Active = 1'b0;
    model_reset();
    idle(3);
    check_reset_outputs("reset");
    i_Reset = 1'b0;

    // timebase and blink phase
    send_cmd(8'hE2, 8'h00);
    expect_tx("blink_ack");
    repeat (130) begin
      @(negedge i_Clock);
      chk("pps", o_PPS, exp_pps(n_cyc));
      chk("secs", o_Secs, exp_secs(n_cyc));
      chk("minute", o_Minute, (exp_secs(n_cyc) != 0));
      chk("blink_led", o_LED[2], exp_blink_led(n_cyc));
    end

    // legacy on
    send_byte(8'h31);
    m_mode[1] = 1;
    idle(1);
    chk("legacy_on", o_LED[1], 0);
    expect_quiet("legacy_quiet", 6);

    // ON / PWM / ACK
    send_cmd(8'hA0, 8'h00);
    expect_tx("on_ack");
    idle(1);
    chk("ch0_on", o_LED[0], 0);
    send_cmd(8'hC1, 8'h40);
    expect_tx("pwm40_ack");
    idle(1);
    led_window("pwm40");
    send_cmd(8'hC1, 8'h00);
    expect_tx("pwm0_ack");
    idle(1);
    led_window("pwm0");

    // out-of-range channel
    send_cmd(8'hA7, 8'h55);
    expect_tx("oor_nak");
    idle(1);
    led_window("oor");

    // timeout: next byte after the timeout cycle is legacy
    send_byte(8'h82);
    idle(TMO);
    send_byte(8'h31);
    m_mode[1] = 1;
    idle(1);
    chk("tmo_legacy", o_LED[1], 0);
    expect_quiet("tmo_quiet", 6);

    // data exactly on the timeout cycle is accepted
    send_cmd(8'h80, 8'h00);
    expect_tx("off_ack");
    idle(2);
    chk("ch0_off", o_LED[0], 1);
    exp_q.push_back(model_cmd(8'hA0, 8'h00));
    send_byte(8'hA0);
    idle(TMO - 1);
    send_byte(8'h00);
    expect_tx("edge_ack");
    idle(1);
    chk("edge_on", o_LED[0], 0);
    led_window("edge");

    // backpressure: latest response wins
    i_TX_Active = 1'b1;
    void'(model_cmd(8'hA0, 8'h11));
    send_byte(8'hA0);
    send_byte(8'h11);
    rsp = model_cmd(8'hA7, 8'h22);
    send_byte(8'hA7);
    send_byte(8'h22);
    idle(10);
    chk("bp_hold", obs_q.size(), 0);
    i_TX_Active = 1'b0;
    idle(10);
    chk("bp_count", obs_q.size(), 1);
    chk("bp_byte", (obs_q.size() != 0) ? obs_q.pop_front() : 8'hFF, rsp);
    chk("bp_txbyte_hold", o_TX_Byte, rsp);
    obs_q.delete();

    // randomized commands, with occasional legacy bytes
    for (int it = 0; it < 12; it++) begin
      hdr = 8'h80 | 8'($urandom_range(0, 3) << 5) | 8'($urandom_range(0, 4));
      dat = 8'($urandom_range(0, 255));
      send_cmd(hdr, dat);
      expect_tx($sformatf("rand_rsp%0d", it));
      if ($urandom_range(0, 1) == 1) begin
        dat = ($urandom_range(0, 1) == 1) ? 8'h31 : 8'($urandom_range(0, 127));
        send_byte(dat);
        m_mode[1] = (dat == 8'h31) ? 1 : 0;
        expect_quiet($sformatf("rand_legacy%0d", it), 3);
      end
      idle(1);
      led_window($sformatf("rand%0d", it));
    end

    // reset mid-command discards header and pending response
    i_TX_Active = 1'b1;
    void'(model_cmd(8'hA2, 8'h00));
    send_byte(8'hA2);
    send_byte(8'h00);
    send_byte(8'h85);
    i_Reset = 1'b1;
    i_TX_Active = 1'b0;
    idle(2);
    check_reset_outputs("midreset");
    model_reset();
    obs_q.delete();
    exp_q.delete();
    i_Reset = 1'b0;
    send_byte(8'h10);
    idle(2);
    chk("post_reset_led", o_LED, {N_CH{1'b1}});
    expect_quiet("post_reset_quiet", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
